// File: rtl/scurve_pkg.sv
// Shared constants and FSM encoding for the S-curve FIFO read / uplink path.
package scurve_pkg;
  localparam int          DATA_W_DEF   = 16;
  localparam logic [15:0] HDR_WORD_DEF = 16'hFF45;
  localparam logic [7:0]  TRL_TAG      = 8'hFF;
  localparam int          PKT_LEN_MIN  = 1;
  localparam int          PKT_LEN_MAX  = 255;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_REQ  = 3'd2,
    ST_WAIT = 3'd3,
    ST_OUT  = 3'd4,
    ST_TRL  = 3'd5
  } drain_state_e;
endpackage

// File: rtl/drain_out_reg.sv
// Uplink holding register: presents one word on m_data/m_valid and keeps it
// stable until the consumer accepts it.
module drain_out_reg import scurve_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_n,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              hs
);
  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && m_ready) valid_d = 1'b0;
    // a load may coincide with the handshake of the previous word (OUT -> TRL)
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  always_ff @(posedge clk_n or posedge rst_n) begin
    if (rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign hs      = valid_q && m_ready;
  assign m_valid = valid_q;
  assign m_data  = data_q;
endmodule

// File: rtl/scurve_fifo_drain.sv
// Read side of the S-curve data FIFO: pops words one at a time and frames them
// as header + payload + trailer packets on the uplink valid/ready stream.
module scurve_fifo_drain import scurve_pkg::*; #(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                PKT_LEN  = 16,
  parameter int                RD_LAT   = 2,
  parameter logic [DATA_W-1:0] HDR_WORD = DATA_W'(HDR_WORD_DEF)
) (
  input  logic              clk_n,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              flush,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic [15:0]       pkt_count
);
  localparam int PKT_LEN_C = (PKT_LEN < PKT_LEN_MIN) ? PKT_LEN_MIN :
                             (PKT_LEN > PKT_LEN_MAX) ? PKT_LEN_MAX : PKT_LEN;
  localparam logic [7:0]        PKT_LEN_B = 8'(PKT_LEN_C);
  localparam int                WAIT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 1);

  drain_state_e      state_d, state_q;
  logic [7:0]        word_cnt_d, word_cnt_q;
  logic [15:0]       pkt_count_d, pkt_count_q;
  logic [WAIT_W-1:0] wait_cnt_d, wait_cnt_q;
  logic              flush_pend_d, flush_pend_q;
  logic              load, hs, rd_en;
  logic [DATA_W-1:0] load_data;

  function automatic logic [DATA_W-1:0] trailer(input logic [7:0] cnt);
    return DATA_W'({TRL_TAG, cnt});
  endfunction

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    pkt_count_d  = pkt_count_q;
    wait_cnt_d   = wait_cnt_q;
    // flush pulses arriving mid-word are held until the next REQ
    flush_pend_d = flush_pend_q | (flush & ((state_q == ST_WAIT) | (state_q == ST_OUT)));
    rd_en        = 1'b0;
    load         = 1'b0;
    load_data    = HDR_WORD;
    case (state_q)
      ST_IDLE: begin
        if (enable && !fifo_empty) begin
          state_d      = ST_HDR;
          load         = 1'b1;
          load_data    = HDR_WORD;
          flush_pend_d = 1'b0;
        end
      end
      ST_HDR: if (hs) state_d = ST_REQ;
      ST_REQ: begin
        if (flush || flush_pend_q || !enable) begin
          if (word_cnt_q != 8'd0) begin
            state_d   = ST_TRL;
            load      = 1'b1;
            load_data = trailer(word_cnt_q);
          end else begin
            state_d = ST_IDLE;
          end
        end else if (!fifo_empty) begin
          rd_en      = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d   = ST_OUT;
          load      = 1'b1;
          load_data = fifo_dout;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_OUT: begin
        if (hs) begin
          word_cnt_d = word_cnt_q + 8'd1;
          if (word_cnt_d == PKT_LEN_B) begin
            state_d   = ST_TRL;
            load      = 1'b1;
            load_data = trailer(word_cnt_d);
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_TRL: begin
        if (hs) begin
          pkt_count_d  = pkt_count_q + 16'd1;
          word_cnt_d   = 8'd0;
          flush_pend_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_n or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= ST_IDLE;
      word_cnt_q   <= 8'd0;
      pkt_count_q  <= 16'd0;
      wait_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      pkt_count_q  <= pkt_count_d;
      wait_cnt_q   <= wait_cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  drain_out_reg #(.DATA_W(DATA_W)) u_out (
    .clk_n     (clk_n),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (load_data),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .hs        (hs)
  );

  assign fifo_rd_en = rd_en;
  assign busy       = (state_q != ST_IDLE);
  assign pkt_count  = pkt_count_q;
endmodule

// File: tb/tb_scurve_fifo_drain.sv
// Bench for scurve_fifo_drain: FIFO model with two-edge read latency, an uplink
// stream monitor and a packet-framing reference model.
`timescale 1ns/1ps
module tb_scurve_fifo_drain;
  logic        clk_n = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0, flush = 1'b0, m_ready = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [15:0] fifo_dout = 16'd0;
  logic        fifo_rd_en, m_valid, busy;
  logic [15:0] m_data, pkt_count;

  scurve_fifo_drain #(.DATA_W(16), .PKT_LEN(16), .RD_LAT(2), .HDR_WORD(16'hFF45)) dut (
    .clk_n(clk_n), .rst_n(rst_n), .enable(enable), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .pkt_count(pkt_count)
  );

  always #5 clk_n = ~clk_n;

  // FIFO model: rd_en sampled at E0, dout at E1, empty updated on the falling edge
  logic [15:0] mem [256];
  int          wr_ptr = 0, rd_ptr = 0;
  logic        rd_pend = 1'b0, rd_s = 1'b0;

  always @(posedge clk_n or posedge rst_n) begin
    if (rst_n) begin
      rd_ptr  <= 0;
      rd_pend <= 1'b0;
    end else begin
      if (rd_pend) begin
        fifo_dout <= mem[rd_ptr[7:0]];
        rd_ptr    <= rd_ptr + 1;
      end
      rd_pend <= rd_s;
    end
  end

  always @(negedge clk_n) fifo_empty <= (rd_ptr == wr_ptr);

  // Monitor samples 1 ns before each rising edge
  typedef struct { int kind; logic [31:0] act; logic [31:0] exp; } mon_t;
  mon_t        mon_q[$];
  logic [15:0] out_q[$];
  int          rd_cyc[$];
  int          cyc = 0;
  logic        stall_prev = 1'b0;
  logic [15:0] prev_data = 16'd0;

  always @(negedge clk_n) begin
    #4;
    cyc++;
    if (rst_n) begin
      rd_s       = 1'b0;
      stall_prev = 1'b0;
    end else begin
      rd_s = fifo_rd_en;
      if (stall_prev)
        mon_q.push_back('{0, {15'd0, m_valid, m_data}, {15'd0, 1'b1, prev_data}});
      if (fifo_rd_en) begin
        rd_cyc.push_back(cyc);
        mon_q.push_back('{1, {30'd0, fifo_empty, m_valid}, 32'd0});
      end
      if (m_valid && m_ready) out_q.push_back(m_data);
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  int n_tests = 0, n_fail = 0, mon_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drain_mon();
    while (mon_idx < mon_q.size()) begin
      check(mon_q[mon_idx].kind == 0 ? "stall_hold" : "rd_guard",
            mon_q[mon_idx].act, mon_q[mon_idx].exp);
      mon_idx++;
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_n);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b1; enable = 1'b0; flush = 1'b0; m_ready = 1'b0; wr_ptr = 0;
    tick(3);
    rst_n = 1'b0;
    tick();
  endtask

  task automatic push(input logic [15:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr++;
  endtask

  task automatic wait_out(input int ob, input int n, input int max_cyc);
    int k = 0;
    while (out_q.size() - ob < n && k < max_cyc) begin tick(); k++; end
    check("wait_out", 32'(out_q.size() - ob), 32'(n));
  endtask

  // Reference model: split the word list into packets of at most 16 payload words
  logic [15:0] words_q[$], exp_q[$];

  function automatic void model_packets();
    int n = words_q.size();
    exp_q.delete();
    for (int s = 0; s < n; s += 16) begin
      int len = (n - s < 16) ? n - s : 16;
      exp_q.push_back(16'hFF45);
      for (int k = 0; k < len; k++) exp_q.push_back(words_q[s + k]);
      exp_q.push_back({8'hFF, 8'(len)});
    end
  endfunction

  // ready_mode: 0 always ready, 1 ready one cycle in three, 2 random
  task automatic drain(input int ready_mode, input bit chk_gap);
    int          n = words_q.size();
    int          ob = out_q.size();
    int          rb = rd_cyc.size();
    logic [15:0] pc0 = pkt_count;
    int          k = 0;
    bit          flushed = 1'b0;
    model_packets();
    foreach (words_q[i]) push(words_q[i]);
    enable = 1'b1;
    while (out_q.size() - ob < exp_q.size() && k < 2000) begin
      m_ready = (ready_mode == 0) ? 1'b1 :
                (ready_mode == 1) ? (k % 3 == 2) : 1'($urandom_range(0, 1));
      flush = (n % 16 != 0) && !flushed && (out_q.size() - ob == exp_q.size() - 1);
      if (flush) flushed = 1'b1;
      tick();
      k++;
    end
    flush = 1'b0; m_ready = 1'b1;
    tick(6);
    check("stream_len", 32'(out_q.size() - ob), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && ob + i < out_q.size(); i++)
      check("stream_word", 32'(out_q[ob + i]), 32'(exp_q[i]));
    check("rd_pulses", 32'(rd_cyc.size() - rb), 32'(n));
    check("pkt_count", 32'(16'(pkt_count - pc0)), 32'((n + 15) / 16));
    check("busy_end", 32'(busy), 32'd0);
    if (chk_gap)
      for (int i = rb + 1; i < rd_cyc.size(); i++)
        check("rd_gap", 32'(rd_cyc[i] - rd_cyc[i-1]), 32'd4);
    drain_mon();
  endtask

  typedef struct { int nwords; logic [15:0] first; int exp_len; logic [15:0] exp_trl; } vec_t;
  vec_t vecs[4];

  initial begin
    #800000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1);
  end

  initial begin
    int ob, rb, k;
    vecs[0] = '{16, 16'h0001, 18, 16'hFF10};
    vecs[1] = '{3,  16'h0A00, 5,  16'hFF03};
    vecs[2] = '{1,  16'h1234, 3,  16'hFF01};
    vecs[3] = '{7,  16'h8000, 9,  16'hFF07};

    // Reset state and idle with an empty FIFO
    tick(3);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pkt_count", 32'(pkt_count), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    rst_n = 1'b0; enable = 1'b1; m_ready = 1'b1;
    rb = rd_cyc.size();
    tick(10);
    check("idle_rd_pulses", 32'(rd_cyc.size() - rb), 32'd0);
    check("idle_m_valid", 32'(m_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Table: full packet and flushed partial packets
    foreach (vecs[v]) begin
      do_reset();
      words_q.delete();
      for (int i = 0; i < vecs[v].nwords; i++) words_q.push_back(vecs[v].first + 16'(i));
      ob = out_q.size();
      drain(0, 1'b1);
      check("tbl_len", 32'(out_q.size() - ob), 32'(vecs[v].exp_len));
      if (out_q.size() >= ob + vecs[v].exp_len)
        check("tbl_trailer", 32'(out_q[ob + vecs[v].exp_len - 1]), 32'(vecs[v].exp_trl));
    end

    // Backpressure: ready one cycle in three
    do_reset();
    words_q = '{16'hB001, 16'hB002, 16'hB003, 16'hB004, 16'hB005};
    drain(1, 1'b0);

    // Empty guard: one word, then FIFO stays empty for 20 cycles
    do_reset();
    ob = out_q.size(); rb = rd_cyc.size();
    push(16'h5A5A); enable = 1'b1; m_ready = 1'b1;
    wait_out(ob, 2, 50);
    tick(20);
    check("guard_rd_pulses", 32'(rd_cyc.size() - rb), 32'd1);
    check("guard_busy", 32'(busy), 32'd1);
    check("guard_m_valid", 32'(m_valid), 32'd0);
    flush = 1'b1; tick(); flush = 1'b0; tick(5);
    check("guard_len", 32'(out_q.size() - ob), 32'd3);
    if (out_q.size() >= ob + 3) check("guard_trailer", 32'(out_q[ob + 2]), 32'hFF01);
    check("guard_pkt_count", 32'(pkt_count), 32'd1);
    drain_mon();

    // enable dropped during header: packet abandoned without trailer
    do_reset();
    ob = out_q.size(); rb = rd_cyc.size();
    push(16'h00AA); enable = 1'b1; m_ready = 1'b0;
    tick(4);
    check("hdr_stall_valid", 32'(m_valid), 32'd1);
    check("hdr_stall_data", 32'(m_data), 32'hFF45);
    enable = 1'b0; m_ready = 1'b1;
    tick(5);
    check("noen_busy", 32'(busy), 32'd0);
    check("noen_rd_pulses", 32'(rd_cyc.size() - rb), 32'd0);
    check("noen_len", 32'(out_q.size() - ob), 32'd1);
    check("noen_pkt_count", 32'(pkt_count), 32'd0);
    drain_mon();

    // Reset while OUT is holding a stalled word
    do_reset();
    push(16'h0C01); push(16'h0C02); push(16'h0C03);
    enable = 1'b1; m_ready = 1'b0;
    tick(3);
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    k = 0;
    while (!m_valid && k < 20) begin tick(); k++; end
    check("out_hold_valid", 32'(m_valid), 32'd1);
    check("out_hold_data", 32'(m_data), 32'h0C01);
    @(posedge clk_n); #2;
    rst_n = 1'b1;
    #1;
    check("async_rst_valid", 32'(m_valid), 32'd0);
    check("async_rst_data", 32'(m_data), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    wr_ptr = 0; enable = 1'b0;
    tick(2);
    rst_n = 1'b0;
    tick();
    check("post_rst_pkt_count", 32'(pkt_count), 32'd0);
    words_q = '{16'h0D01, 16'h0D02};
    drain(0, 1'b0);

    // Randomized packets against the reference model
    for (int t = 0; t < 6; t++) begin
      do_reset();
      words_q.delete();
      for (int i = 0; i < $urandom_range(1, 40); i++) words_q.push_back(16'($urandom));
      drain($urandom_range(0, 2), 1'b0);
    end

    drain_mon();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
